// File: rtl/nt_node_response_reader.sv
// MISR response compactor: samples observed nets for a programmed number of cycles, then shifts the signature out serially.
// Optional golden-signature comparator (golden/mismatch ports) enabled by defining NT_SIG_COMPARE_EN.
module nt_node_response_reader #(
  parameter int               WIDTH = 16,
  parameter int               IN_W  = 4,
  parameter int               CNT_W = 8,
  parameter logic [WIDTH-1:0] POLY  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [IN_W-1:0]  obs_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sig,
  output logic             so_data,
  output logic             so_valid,
  input  logic             so_ready
`ifdef NT_SIG_COMPARE_EN
  ,
  input  logic [WIDTH-1:0] golden,
  output logic             mismatch
`endif
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_misr;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_sig;
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] r_bit_idx;
  logic [WIDTH-1:0] w_misr_step;
  logic             w_start_ok;
  logic             w_last_step;
  logic             w_last_bit;
  logic             w_busy;
  logic             w_done;
  logic             w_so_valid;

  assign w_misr_step = (r_misr >> 1) ^ (r_misr[0] ? POLY : '0) ^ WIDTH'(obs_in);
  assign w_start_ok  = (r_state == S_IDLE) && start;
  assign w_last_step = (r_count == CNT_W'(1));
  assign w_last_bit  = (r_bit_idx == IDX_W'(WIDTH - 1));

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_so_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (num_cycles == '0) ? S_SHIFT : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_busy = 1'b1;
        if (w_last_step) begin
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy     = 1'b1;
        w_so_valid = 1'b1;
        if (so_ready && w_last_bit) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // MISR is left untouched during SHIFT so DONE can publish it; the shift register carries the serial copy.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_misr    <= SEED;
      r_shift   <= '0;
      r_sig     <= SEED;
      r_count   <= '0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_misr    <= SEED;
            r_count   <= num_cycles;
            r_bit_idx <= '0;
            r_shift   <= SEED;
          end
        end
        S_CAPTURE: begin
          r_misr  <= w_misr_step;
          r_count <= r_count - CNT_W'(1);
          if (w_last_step) begin
            r_shift <= w_misr_step;
          end
        end
        S_SHIFT: begin
          if (so_ready) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          r_sig <= r_misr;
        end
        default: ;
      endcase
    end
  end

`ifdef NT_SIG_COMPARE_EN
  logic r_mismatch;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_mismatch <= 1'b0;
    end else if (w_start_ok) begin
      r_mismatch <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_mismatch <= (r_misr != golden);
    end
  end

  assign mismatch = r_mismatch;
`endif

  assign busy     = w_busy;
  assign done     = w_done;
  assign so_valid = w_so_valid;
  assign so_data  = (r_state == S_SHIFT) ? r_shift[0] : 1'b0;
  assign sig      = r_sig;

endmodule

// File: tb/tb_nt_node_response_reader.sv
// Scoreboard bench for nt_node_response_reader: stimulus queues expected bits/signatures, a monitor checks them.
module tb_nt_node_response_reader;
  localparam int WIDTH = 16;
  localparam int IN_W  = 4;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RSTB = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_cycles = '0;
  logic [IN_W-1:0]  obs_in = '0;
  logic             so_ready = 1'b1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sig;
  logic             so_data;
  logic             so_valid;
`ifdef NT_SIG_COMPARE_EN
  logic [WIDTH-1:0] golden = 16'hCBFF;
  logic             mismatch;
`endif

  nt_node_response_reader dut (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .start     (start),
    .num_cycles(num_cycles),
    .obs_in    (obs_in),
    .busy      (busy),
    .done      (done),
    .sig       (sig),
    .so_data   (so_data),
    .so_valid  (so_valid),
    .so_ready  (so_ready)
`ifdef NT_SIG_COMPARE_EN
    ,
    .golden    (golden),
    .mismatch  (mismatch)
`endif
  );

  always #5 CLK = ~CLK;

  int          vectors = 0;
  int          miscompares = 0;
  bit          exp_bits[$];
  logic [15:0] exp_sig_q[$];
  logic [15:0] pend_sig;
  bit          sig_pending = 0;
  bit          hold_pending = 0;
  logic        held_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Monitor: consumes expected bits on each handshake and expected signatures on each done pulse.
  always @(negedge CLK) begin
    if (!RSTB) begin
      sig_pending  = 0;
      hold_pending = 0;
    end else begin
      if (sig_pending) begin
        check("sig", 32'(sig), 32'(pend_sig));
`ifdef NT_SIG_COMPARE_EN
        check("mismatch", 32'(mismatch), 32'(pend_sig != 16'hCBFF));
`endif
        sig_pending = 0;
      end
      if (hold_pending) begin
        check("hold_valid", 32'(so_valid), 32'(1));
        check("hold_data", 32'(so_data), 32'(held_data));
      end
      hold_pending = so_valid && !so_ready;
      held_data    = so_data;
      if (so_valid && so_ready) begin
        if (exp_bits.size() == 0) flag("unexpected_bit");
        else check("so_data", 32'(so_data), 32'(exp_bits.pop_front()));
      end
      if (done) begin
        check("done_valid_low", 32'(so_valid), 32'(0));
        if (exp_sig_q.size() == 0) flag("unexpected_done");
        else begin
          pend_sig    = exp_sig_q.pop_front();
          sig_pending = 1;
        end
      end
    end
  end

  function automatic logic ready_val(input int mode, input int c, input int n);
    if (mode == 1) return (c >= n) && (((c - n) % 2) == 1);
    return 1'b1;
  endfunction

  function automatic logic [15:0] misr_model(input int n, input logic [3:0] obs);
    logic [15:0] m = 16'hFFFF;
    for (int i = 0; i < n; i++) m = (m >> 1) ^ (m[0] ? 16'hB400 : 16'h0000) ^ {12'h000, obs};
    return m;
  endfunction

  // mode 0: ready high; mode 1: ready toggles from first SHIFT cycle; mode 2: stray start mid-shift.
  task automatic run(input string name, input int n, input logic [3:0] obs, input int mode,
                     input logic [15:0] exp_sig);
    int c;
    int busy_cnt;
    bit seen;
    int exp_busy;
    for (int i = 0; i < 16; i++) exp_bits.push_back(exp_sig[i]);
    exp_sig_q.push_back(exp_sig);
    exp_busy = n + ((mode == 1) ? 32 : 16);
    @(posedge CLK); #1;
    start = 1'b1; num_cycles = CNT_W'(n); obs_in = obs; so_ready = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; c = 0; so_ready = ready_val(mode, c, n);
`ifdef NT_SIG_COMPARE_EN
    check("mismatch_clear", 32'(mismatch), 32'(0));
`endif
    busy_cnt = 0;
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge CLK);
      if (busy) busy_cnt++;
      if (done) seen = 1;
      @(posedge CLK); #1;
      c++;
      so_ready = ready_val(mode, c, n);
      if (mode == 2) begin
        start = (c == n + 3);
        if (c == n + 3) num_cycles = 8'd5;
      end
    end
    start = 1'b0;
    so_ready = 1'b1;
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: got no done, expected done within 400 cycles", name);
    end
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    $display("%s: n=%0d obs=%h mode=%0d exp_sig=%h busy_cycles=%0d", name, n, obs, mode, exp_sig, busy_cnt);
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_valid", 32'(so_valid), 32'(0));
    check("rst_data", 32'(so_data), 32'(0));
    check("rst_sig", 32'(sig), 32'(16'hFFFF));
`ifdef NT_SIG_COMPARE_EN
    check("rst_mismatch", 32'(mismatch), 32'(0));
`endif
    $display("reset: busy=%b done=%b so_valid=%b sig=%h", busy, done, so_valid, sig);
    @(posedge CLK); #1;
    RSTB = 1'b1;

    run("n0_seed", 0, 4'h0, 0, 16'hFFFF);
    run("n1_obs0", 1, 4'h0, 0, 16'hCBFF);
    run("n1_obsF", 1, 4'hF, 0, 16'hCBF0);
    run("n1_toggle", 1, 4'h0, 1, 16'hCBFF);
    run("n2_obs0", 2, 4'h0, 0, 16'hD1FF);
    run("stray_start", 1, 4'h0, 2, 16'hCBFF);
    run("n255_obs5", 255, 4'h5, 0, misr_model(255, 4'h5));

    // Abort a 10-cycle capture after 3 steps.
    @(posedge CLK); #1;
    start = 1'b1; num_cycles = 8'd10; obs_in = 4'h0;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RSTB = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_valid", 32'(so_valid), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_sig", 32'(sig), 32'(16'hFFFF));
    $display("abort: busy=%b so_valid=%b sig=%h", busy, so_valid, sig);
    repeat (2) @(posedge CLK);
    #1 RSTB = 1'b1;
    repeat (30) @(posedge CLK);
    run("after_abort", 1, 4'h0, 0, 16'hCBFF);

    repeat (4) @(posedge CLK);
    check("left_bits", 32'(exp_bits.size()), 32'(0));
    check("left_sigs", 32'(exp_sig_q.size()), 32'(0));
    check("left_pending", 32'(sig_pending), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
